sha256_msg_padder: RTL

- Upstream feeder for the sha256 core.
- Accepts a byte message as a stream of 32-bit beats and performs FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length.
- Presents each 512-bit chunk to the core as 16 back-to-back words on dat_valid_o/dat_lsb_o, then waits for the core's busy cycle to complete before sending the next chunk.
- Byte order matches the core's input convention: the earliest message byte sits in bits [7:0].

---
 rtl/sha256_msg_padder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: FIPS 180-4 padding front end for the sha256 core.
// Collects one 512-bit chunk, then streams it as 16 words with the earliest byte in bits [7:0].
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  input  logic [2:0]  s_bytes_i,
  input  logic        s_last_i,
  input  logic        core_busy_i,
  output logic        dat_valid_o,
  output logic [31:0] dat_lsb_o,
  output logic        busy_o,
  output logic        msg_done_o
);

  // state       | meaning
  // S_IDLE      | no message in progress, waiting for start_i
  // S_FILL      | accepting message beats into the chunk buffer
  // S_PAD       | one cycle: place the length words or defer them to an extra chunk
  // S_SEND      | 16 back-to-back words to the core
  // S_WAIT_BUSY | waiting for the core to report busy
  // S_WAIT_DONE | waiting for the core to finish the chunk
  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       buf_q [16];
  logic [4:0]        wp_q;
  logic [4:0]        pad_idx_q;
  logic [LEN_W-1:0]  byte_cnt_q;
  logic [3:0]        send_left_q;
  logic              final_q;
  logic              pad_pend_q;
  logic              len_pend_q;

  logic [2:0]        eff_bytes;
  logic [31:0]       beat_word;
  logic [4:0]        pad_at;
  logic [63:0]       len_bits;
  logic [31:0]       len_hi_w;
  logic [31:0]       len_lo_w;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Short beats only count on the last beat; everything else is a full word.
  always_comb begin
    eff_bytes = 3'd4;
    if (s_last_i && (s_bytes_i < 3'd4)) eff_bytes = s_bytes_i;
  end

  // Mask unused bytes and drop the 0x80 marker right after the last valid byte.
  always_comb begin
    beat_word = '0;
    for (int n = 0; n < 4; n++) begin
      if (3'(n) < eff_bytes)       beat_word[8*n +: 8] = s_data_i[8*n +: 8];
      else if (3'(n) == eff_bytes) beat_word[8*n +: 8] = 8'h80;
    end
  end

  assign pad_at   = (eff_bytes == 3'd4) ? (wp_q + 5'd1) : wp_q;
  assign len_bits = 64'(byte_cnt_q) << 3;
  assign len_hi_w = bswap(len_bits[63:32]);
  assign len_lo_w = bswap(len_bits[31:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    s_ready_o   = 1'b0;
    dat_valid_o = 1'b0;
    dat_lsb_o   = '0;
    busy_o      = (state_q != S_IDLE);
    msg_done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FILL;
      end
      S_FILL: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          if (s_last_i)           state_d = (pad_at == 5'd16) ? S_SEND : S_PAD;
          else if (wp_q == 5'd15) state_d = S_SEND;
        end
      end
      S_PAD: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        dat_valid_o = 1'b1;
        dat_lsb_o   = buf_q[~send_left_q];
        if (send_left_q == 4'd0) state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (core_busy_i) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!core_busy_i) begin
          if (final_q) begin
            msg_done_o = 1'b1;
            state_d    = S_IDLE;
          end else if (pad_pend_q || len_pend_q) begin
            state_d = S_SEND;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      wp_q        <= '0;
      pad_idx_q   <= '0;
      byte_cnt_q  <= '0;
      send_left_q <= 4'd15;
      final_q     <= 1'b0;
      pad_pend_q  <= 1'b0;
      len_pend_q  <= 1'b0;
    end else begin
      // Down-counter; word index is its complement so words leave in order 0..15.
      send_left_q <= (state_q == S_SEND) ? (send_left_q - 4'd1) : 4'd15;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            for (int i = 0; i < 16; i++) buf_q[i] <= '0;
            wp_q       <= '0;
            pad_idx_q  <= '0;
            byte_cnt_q <= '0;
            final_q    <= 1'b0;
            pad_pend_q <= 1'b0;
            len_pend_q <= 1'b0;
          end
        end
        S_FILL: begin
          if (s_valid_i) begin
            buf_q[wp_q[3:0]] <= beat_word;
            if (s_last_i && (eff_bytes == 3'd4) && (pad_at != 5'd16))
              buf_q[pad_at[3:0]] <= 32'h0000_0080;
            if (eff_bytes != 3'd0) wp_q <= wp_q + 5'd1;
            byte_cnt_q <= byte_cnt_q + LEN_W'(eff_bytes);
            if (s_last_i) begin
              pad_idx_q <= pad_at;
              if (pad_at == 5'd16) pad_pend_q <= 1'b1;
            end
          end
        end
        S_PAD: begin
          // Length fits only if the 0x80 word leaves words 14/15 free.
          if (pad_idx_q <= 5'd13) begin
            buf_q[14] <= len_hi_w;
            buf_q[15] <= len_lo_w;
            final_q   <= 1'b1;
          end else begin
            len_pend_q <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!core_busy_i) begin
            if (final_q) begin
              final_q <= 1'b0;
            end else begin
              for (int i = 0; i < 16; i++) buf_q[i] <= '0;
              wp_q <= '0;
              if (pad_pend_q || len_pend_q) begin
                if (pad_pend_q) buf_q[0] <= 32'h0000_0080;
                buf_q[14]  <= len_hi_w;
                buf_q[15]  <= len_lo_w;
                final_q    <= 1'b1;
                pad_pend_q <= 1'b0;
                len_pend_q <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
